// File: rtl/csa_accum_sequencer_pkg.sv
// Shared definitions for the carry-save accumulator sequencer.
//   state_t         : FSM encodings (ACCUM=0, RESOLVE=1, DONE=2)
//   cnt53_t         : outputs of one 5:3 counter cell
//   counter_5_to_3  : bit-level 5:3 counter, x1+x2+x3+x4+cin = s + 2*(c + cout)
package csa_accum_sequencer_pkg;

   typedef enum logic [1:0] {
      ST_ACCUM   = 2'd0,
      ST_RESOLVE = 2'd1,
      ST_DONE    = 2'd2
   } state_t;

   typedef struct packed {
      logic s;
      logic c;
      logic cout;
   } cnt53_t;

   // cout depends only on x1..x3, so chaining cout->cin along a row
   // never forms a ripple path longer than one cell.
   function automatic cnt53_t counter_5_to_3(input logic x1, input logic x2,
                                             input logic x3, input logic x4,
                                             input logic cin);
      cnt53_t r;
      logic   p;
      p      = x1 ^ x2 ^ x3;
      r.cout = (x1 & x2) | (x1 & x3) | (x2 & x3);
      r.s    = p ^ x4 ^ cin;
      r.c    = (p & x4) | (p & cin) | (x4 & cin);
      return r;
   endfunction

endpackage

// File: rtl/csa_accum_sequencer_row.sv
// Combinational row of W 5:3 counter cells folding two new operands into a
// carry-save pair.
//   i_a, i_b : zero-extended operands (W)
//   i_s, i_c : current carry-save state (W)
//   o_s      : new sum vector (W)
//   o_c      : new carry vector, already shifted left by one (W)
// The cout of the top cell and the top c bit fall outside W and are dropped.
module csa_row_5_to_3
   import csa_accum_sequencer_pkg::*;
#(
   parameter int unsigned W = 24
) (
   input  logic [W-1:0] i_a,
   input  logic [W-1:0] i_b,
   input  logic [W-1:0] i_s,
   input  logic [W-1:0] i_c,
   output logic [W-1:0] o_s,
   output logic [W-1:0] o_c
);

   always_comb begin
      cnt53_t w_cell;
      logic   w_carry;
      o_s     = '0;
      o_c     = '0;
      w_carry = 1'b0;
      w_cell  = '0;
      for (int unsigned i = 0; i < W; i++) begin
         w_cell  = counter_5_to_3(i_a[i], i_b[i], i_s[i], i_c[i], w_carry);
         o_s[i]  = w_cell.s;
         if (i < W - 1) begin
            o_c[i+1] = w_cell.c;
         end
         w_carry = w_cell.cout;
      end
   end

endmodule

// File: rtl/csa_accum_sequencer.sv
// Carry-save multi-operand accumulator with valid/ready on both sides.
//   clk, reset          : clock, synchronous active-high reset
//   in_valid/in_ready   : operand beat handshake
//   in_a, in_b          : operands (OP_W), zero-extended to ACC_W
//   in_last             : final beat of the current sum
//   out_valid/out_ready : result handshake
//   out_sum             : sum of all beat operands mod 2^ACC_W
//   out_beats           : beats accepted for this sum, saturating at 2^CNT_W-1
module csa_accum_sequencer
   import csa_accum_sequencer_pkg::*;
#(
   parameter int unsigned OP_W  = 16,
   parameter int unsigned ACC_W = 24,
   parameter int unsigned CNT_W = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [OP_W-1:0]  in_a,
   input  logic [OP_W-1:0]  in_b,
   input  logic             in_last,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [ACC_W-1:0] out_sum,
   output logic [CNT_W-1:0] out_beats
);

   state_t             r_state;
   logic [ACC_W-1:0]   r_acc_s;
   logic [ACC_W-1:0]   r_acc_c;
   logic [CNT_W-1:0]   r_count;
   logic [ACC_W-1:0]   r_out_sum;
   logic [CNT_W-1:0]   r_out_beats;
   logic               r_out_valid;

   logic [ACC_W-1:0]   w_a_ext;
   logic [ACC_W-1:0]   w_b_ext;
   logic [ACC_W-1:0]   w_row_s;
   logic [ACC_W-1:0]   w_row_c;

   assign w_a_ext = ACC_W'(in_a);
   assign w_b_ext = ACC_W'(in_b);

   csa_row_5_to_3 #(.W(ACC_W)) u_row (
      .i_a (w_a_ext),
      .i_b (w_b_ext),
      .i_s (r_acc_s),
      .i_c (r_acc_c),
      .o_s (w_row_s),
      .o_c (w_row_c)
   );

   // Gated by reset so the sequencer is visibly not ready while reset is held,
   // yet ready in the very first cycle after release.
   assign in_ready  = (r_state == ST_ACCUM) && !reset;
   assign out_valid = r_out_valid;
   assign out_sum   = r_out_sum;
   assign out_beats = r_out_beats;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= ST_ACCUM;
         r_acc_s     <= '0;
         r_acc_c     <= '0;
         r_count     <= '0;
         r_out_sum   <= '0;
         r_out_beats <= '0;
         r_out_valid <= 1'b0;
      end else begin
         case (r_state)
            ST_ACCUM: begin
               if (in_valid) begin
                  r_acc_s <= w_row_s;
                  r_acc_c <= w_row_c;
                  if (r_count != '1) begin
                     r_count <= r_count + 1'b1;
                  end
                  if (in_last) begin
                     r_state <= ST_RESOLVE;
                  end
               end
            end
            ST_RESOLVE: begin
               r_out_sum   <= r_acc_s + r_acc_c;
               r_out_beats <= r_count;
               r_out_valid <= 1'b1;
               r_state     <= ST_DONE;
            end
            ST_DONE: begin
               if (out_ready) begin
                  r_acc_s     <= '0;
                  r_acc_c     <= '0;
                  r_count     <= '0;
                  r_out_valid <= 1'b0;
                  r_state     <= ST_ACCUM;
               end
            end
            default: begin
               r_state <= ST_ACCUM;
            end
         endcase
      end
   end

endmodule
